// File: rtl/sha_reg_initiator.sv
// Register-bus initiator for the hash blocks: loads a message block with word writes
// and reads the digest back with word reads, one outstanding transaction at a time.
module sha_reg_initiator #(
  parameter int unsigned          DataWidth   = 64,
  parameter int unsigned          AddrWidth   = 32,
  parameter int unsigned          DataBytes   = DataWidth >> 3,
  parameter bit                   ByteAlign   = 1'b1,
  parameter int unsigned          BlockWidth  = 512,
  parameter int unsigned          DigestWidth = 256,
  parameter logic [AddrWidth-1:0] BlockAddr   = 'h00,
  parameter logic [AddrWidth-1:0] DigestAddr  = 'h40
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_write_i,
  input  logic [BlockWidth-1:0]  block_i,
  output logic                   done_o,
  output logic                   error_o,
  output logic [DigestWidth-1:0] digest_o,
  output logic [DataWidth-1:0]   reqdata_o,
  output logic [AddrWidth-1:0]   reqaddr_o,
  output logic                   reqvalid_o,
  output logic                   reqwrite_o,
  input  logic                   reqready_i,
  output logic [DataBytes-1:0]   reqstrobe_o,
  output logic                   rspready_o,
  input  logic                   rspvalid_i,
  input  logic [DataWidth-1:0]   rspdata_i,
  input  logic                   rsperror_i
);

  localparam int unsigned NBlk = BlockWidth / DataWidth;
  localparam int unsigned NDig = DigestWidth / DataWidth;
  localparam int unsigned NMax = (NBlk > NDig) ? NBlk : NDig;
  localparam int unsigned CW   = (NMax > 1) ? $clog2(NMax) : 1;

  localparam logic [CW-1:0]        LastBlk = CW'(NBlk - 1);
  localparam logic [CW-1:0]        LastDig = CW'(NDig - 1);
  localparam logic [AddrWidth-1:0] Step    = ByteAlign ? AddrWidth'(DataBytes) : AddrWidth'(1);

  if (BlockWidth % DataWidth != 0) begin : g_block_chk
    $error("BlockWidth must be a multiple of DataWidth");
  end
  if (DigestWidth % DataWidth != 0) begin : g_digest_chk
    $error("DigestWidth must be a multiple of DataWidth");
  end

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          k_q;
  logic                   wr_q;
  logic                   err_q;
  logic [BlockWidth-1:0]  block_q;
  logic [DigestWidth-1:0] digest_q;
  logic [DataWidth-1:0]   blk_word;
  logic                   last_word;

  assign last_word = wr_q ? (k_q == LastBlk) : (k_q == LastDig);
  assign digest_o  = digest_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid_i) state_d = REQ;
      REQ:     if (reqready_i) state_d = RSP;
      RSP:     if (rspvalid_i) state_d = (rsperror_i || last_word) ? DONE : REQ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An errored word leaves the digest and the word counter untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      k_q      <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      block_q  <= '0;
      digest_q <= '0;
    end else begin
      if (state_q == IDLE && cmd_valid_i) begin
        wr_q    <= cmd_write_i;
        block_q <= block_i;
        k_q     <= '0;
        err_q   <= 1'b0;
      end
      if (state_q == RSP && rspvalid_i) begin
        if (rsperror_i) begin
          err_q <= 1'b1;
        end else begin
          if (!wr_q) begin
            for (int unsigned i = 0; i < NDig; i++) begin
              if (k_q == CW'(i)) digest_q[i*DataWidth +: DataWidth] <= rspdata_i;
            end
          end
          if (!last_word) k_q <= k_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    blk_word = '0;
    for (int unsigned i = 0; i < NBlk; i++) begin
      if (k_q == CW'(i)) blk_word = block_q[i*DataWidth +: DataWidth];
    end
  end

  // cmd_ready_o is gated by reset so that every output reads 0 while reset is held.
  always_comb begin
    cmd_ready_o = (state_q == IDLE) && !rst_i;
    reqvalid_o  = 1'b0;
    reqwrite_o  = 1'b0;
    reqaddr_o   = '0;
    reqdata_o   = '0;
    reqstrobe_o = '0;
    rspready_o  = 1'b0;
    done_o      = 1'b0;
    error_o     = 1'b0;
    unique case (state_q)
      REQ: begin
        reqvalid_o = 1'b1;
        reqwrite_o = wr_q;
        reqaddr_o  = (wr_q ? BlockAddr : DigestAddr) + AddrWidth'(k_q) * Step;
        if (wr_q) begin
          reqdata_o   = blk_word;
          reqstrobe_o = '1;
        end
      end
      RSP:  rspready_o = 1'b1;
      DONE: begin
        done_o  = 1'b1;
        error_o = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sha_reg_initiator.sv
// Bench for sha_reg_initiator: a byte-aligned and a word-aligned instance share one
// stimulus stream; expected requests are queued per command and popped on handshake.
module tb_sha_reg_initiator;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_write;
  logic [511:0] block;
  logic         reqready, rspvalid, rsperror;
  logic [63:0]  rspdata;

  logic         cmd_ready, done, error1, reqvalid, reqwrite, rspready;
  logic [255:0] digest;
  logic [63:0]  reqdata;
  logic [31:0]  reqaddr;
  logic [7:0]   reqstrobe;

  logic         cmd_ready_b, done_b, error_b, reqvalid_b, reqwrite_b, rspready_b;
  logic [255:0] digest_b;
  logic [63:0]  reqdata_b;
  logic [31:0]  reqaddr_b;
  logic [7:0]   reqstrobe_b;

  always #5 clk = ~clk;

  sha_reg_initiator #(.ByteAlign(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_write_i(cmd_write), .block_i(block), .done_o(done), .error_o(error1),
    .digest_o(digest), .reqdata_o(reqdata), .reqaddr_o(reqaddr), .reqvalid_o(reqvalid),
    .reqwrite_o(reqwrite), .reqready_i(reqready), .reqstrobe_o(reqstrobe),
    .rspready_o(rspready), .rspvalid_i(rspvalid), .rspdata_i(rspdata), .rsperror_i(rsperror)
  );

  sha_reg_initiator #(.ByteAlign(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_b),
    .cmd_write_i(cmd_write), .block_i(block), .done_o(done_b), .error_o(error_b),
    .digest_o(digest_b), .reqdata_o(reqdata_b), .reqaddr_o(reqaddr_b), .reqvalid_o(reqvalid_b),
    .reqwrite_o(reqwrite_b), .reqready_i(reqready), .reqstrobe_o(reqstrobe_b),
    .rspready_o(rspready_b), .rspvalid_i(rspvalid), .rspdata_i(rspdata), .rsperror_i(rsperror)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] addr_b;
    logic        wr;
    logic [63:0] data;
    logic [7:0]  strb;
  } req_t;

  req_t         exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           stall_req_word = -1, stall_req_cyc = 0;
  int           stall_rsp_word = -1, stall_rsp_cyc = 0;
  int           err_word = -1;
  logic [63:0]  rsp_base;
  logic [255:0] exp_digest;
  logic [511:0] blk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero();
    check("rst_cmd_ready", {cmd_ready, cmd_ready_b}, 0);
    check("rst_done_err", {done, error1, done_b, error_b}, 0);
    check("rst_req", {reqvalid, reqwrite, reqaddr, reqdata, reqstrobe, rspready}, 0);
    check("rst_req_b", {reqvalid_b, reqwrite_b, reqaddr_b, reqdata_b, reqstrobe_b, rspready_b}, 0);
    check("rst_digest", digest, 0);
    check("rst_digest_b", digest_b, 0);
  endtask

  // Issues one command, plays the slave cycle by cycle and checks against the queue.
  // abort_cyc > 0 returns at that cycle without waiting for completion.
  task automatic run_cmd(input logic wr, input logic [511:0] b, input int busy_hold,
                         input int abort_cyc);
    int n, nw, exp_done, cyc, hs, rqw, rsw, w;
    logic exp_err, stalled;
    logic [104:0] held;
    req_t e;
    n        = wr ? 8 : 4;
    exp_err  = !wr && err_word >= 0 && err_word < n;
    nw       = exp_err ? err_word + 1 : n;
    exp_done = 1 + 2 * nw;
    if (stall_req_word >= 0 && stall_req_word < nw) exp_done += stall_req_cyc;
    if (stall_rsp_word >= 0 && stall_rsp_word < nw) exp_done += stall_rsp_cyc;
    for (int k = 0; k < nw; k++) begin
      e.addr   = (wr ? 32'h0 : 32'h40) + 32'(k * 8);
      e.addr_b = (wr ? 32'h0 : 32'h40) + 32'(k);
      e.wr     = wr;
      e.data   = wr ? b[k*64 +: 64] : 64'h0;
      e.strb   = wr ? 8'hFF : 8'h00;
      exp_q.push_back(e);
    end
    if (!wr) begin
      for (int k = 0; k < n; k++)
        if (!exp_err || k < err_word) exp_digest[k*64 +: 64] = rsp_base + 64'(k);
    end

    reqready = 1'b1; rspvalid = 1'b0; rsperror = 1'b0;
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_write = wr; block = b; cmd_valid = 1'b1;
    @(posedge clk);
    cyc = 0; hs = 0; rqw = 0; rsw = 0; stalled = 1'b0; held = '0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc == abort_cyc) return;
      if (cyc <= busy_hold) begin
        check("cmd_ready_busy", cmd_ready, 1'b0);
        block = ~b;
        cmd_write = ~wr;
      end else begin
        cmd_valid = 1'b0;
      end
      if (stalled) check("req_stable", {reqvalid, reqaddr, reqwrite, reqdata, reqstrobe}, {1'b1, held});
      if (!done) check("error_without_done", error1, 1'b0);
      if (done || cyc > 80) begin
        check("done_cycle", cyc, exp_done);
        check("error_flag", error1, exp_err);
        check("done_b", {done_b, error_b}, {1'b1, exp_err});
        check("sb_empty", exp_q.size(), 0);
        break;
      end
      stalled = 1'b0;
      reqready = 1'b1;
      if (reqvalid) begin
        if (hs == stall_req_word && rqw < stall_req_cyc) begin
          reqready = 1'b0;
          rqw++;
          stalled = 1'b1;
          held = {reqaddr, reqwrite, reqdata, reqstrobe};
        end else if (exp_q.size() == 0) begin
          check("extra_req_index", hs, nw - 1);
          hs++;
        end else begin
          e = exp_q.pop_front();
          check("req_addr", reqaddr, e.addr);
          check("req_write_data_strb", {reqwrite, reqdata, reqstrobe}, {e.wr, e.data, e.strb});
          check("req_b", {reqvalid_b, reqaddr_b, reqwrite_b, reqdata_b, reqstrobe_b},
                {1'b1, e.addr_b, e.wr, e.data, e.strb});
          hs++;
        end
      end
      if (rspready) begin
        w = hs - 1;
        if (w == stall_rsp_word && rsw < stall_rsp_cyc) begin
          rspvalid = 1'b0;
          rsw++;
        end else begin
          rspvalid = 1'b1;
          rspdata  = rsp_base + 64'(w);
          rsperror = !wr && (w == err_word);
        end
      end else begin
        rspvalid = 1'b0;
        rsperror = 1'b0;
      end
    end
    cmd_valid = 1'b0; rspvalid = 1'b0; rsperror = 1'b0;
    @(negedge clk);
    check("done_one_cycle", {done, error1, reqvalid}, 0);
    check("back_to_idle", cmd_ready, 1'b1);
    check("digest", digest, exp_digest);
    check("digest_b", digest_b, exp_digest);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; block = '0;
    reqready = 1'b1; rspvalid = 1'b0; rsperror = 1'b0; rspdata = '0;
    rsp_base = 64'hA0; exp_digest = '0;
    repeat (2) @(negedge clk);
    check_all_zero();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {cmd_ready, cmd_ready_b}, 2'b11);

    for (int k = 0; k < 8; k++) blk[k*64 +: 64] = 64'(k);
    run_cmd(1'b1, blk, 0, 0);

    rsp_base = 64'hA0;
    run_cmd(1'b0, '0, 0, 0);

    for (int k = 0; k < 16; k++) blk[k*32 +: 32] = $urandom();
    stall_req_word = 2; stall_req_cyc = 3; stall_rsp_word = 5; stall_rsp_cyc = 2;
    run_cmd(1'b1, blk, 0, 0);
    stall_req_word = -1; stall_req_cyc = 0; stall_rsp_word = -1; stall_rsp_cyc = 0;

    rsp_base = 64'hB0; err_word = 1;
    run_cmd(1'b0, '0, 0, 0);
    err_word = -1;

    for (int k = 0; k < 16; k++) blk[k*32 +: 32] = $urandom();
    run_cmd(1'b1, blk, 5, 0);

    run_cmd(1'b1, blk, 0, 9);
    rst = 1'b1;
    #1;
    check_all_zero();
    exp_q.delete();
    exp_digest = '0;
    reqready = 1'b1; rspvalid = 1'b0; rsperror = 1'b0; cmd_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_done_in_reset", {done, done_b}, 2'b00);
    end
    rst = 1'b0;

    for (int k = 0; k < 8; k++) blk[k*64 +: 64] = {32'hC0DE_0000, 32'(k)};
    run_cmd(1'b1, blk, 0, 0);

    rsp_base = 64'hC0;
    run_cmd(1'b0, '0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sha_reg_initiator.md
Name: sha_reg_initiator

Overview:
- Bus initiator for the simple request/response register protocol used by the hash blocks.
- Loads a full message block into a hash block's block registers with sequential word writes.
- Reads the digest registers back with sequential word reads.
- Sits between a local controller (DMA/test sequencer) and a hash block's register slave port; one outstanding transaction at a time.

Parameters:
- DataWidth, 64, bus data width in bits.
- AddrWidth, 32, bus address width.
- DataBytes, DataWidth>>3, strobe width.
- ByteAlign, 1, 1: word address step = DataBytes; 0: step = 1.
- BlockWidth, 512, message block width; must be a multiple of DataWidth (elaboration assertion).
- DigestWidth, 256, digest read-back width; must be a multiple of DataWidth (elaboration assertion).
- BlockAddr, 'h00, address of block word 0.
- DigestAddr, 'h40, address of digest word 0.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_write_i  in  1  1 = load block, 0 = read digest
- block_i  in  BlockWidth  block to write; sampled at command handshake
- done_o  out  1  one-cycle pulse on command completion
- error_o  out  1  valid with done_o; 1 = command aborted on rsperror
- digest_o  out  DigestWidth  assembled digest read-back
- reqdata_o  out  DataWidth  write data
- reqaddr_o  out  AddrWidth  request address
- reqvalid_o  out  1  request valid
- reqwrite_o  out  1  write request
- reqready_i  in  1  slave ready
- reqstrobe_o  out  DataBytes  byte strobe
- rspready_o  out  1  response ready
- rspvalid_i  in  1  response valid
- rspdata_i  in  DataWidth  read data
- rsperror_i  in  1  error response

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. A reset mid-command abandons it immediately, with no done_o.
- FSM states: IDLE, REQ, RSP, DONE.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i, latch cmd_write_i and block_i, clear word counter and error flag, go to REQ.
- Word count N:
  - Write command: N = BlockWidth/DataWidth (8).
  - Read command: N = DigestWidth/DataWidth (4).
- REQ:
  - reqvalid_o = 1.
  - reqaddr_o = base + k*step, where base is BlockAddr (write) or DigestAddr (read).
  - reqwrite_o = latched cmd_write.
  - Writes: reqdata_o = block[k*DataWidth +: DataWidth], reqstrobe_o = all ones.
  - Reads: reqdata_o = 0, reqstrobe_o = 0.
  - All request outputs stay stable while reqvalid_o=1 and reqready_i=0.
  - On reqvalid_o & reqready_i, go to RSP.
- RSP:
  - rspready_o = 1, reqvalid_o = 0.
  - On rspvalid_i with rsperror_i=1, set the error flag and go to DONE. Remaining words are not issued.
  - On rspvalid_i without error:
    - For a read, digest_o[k*DataWidth +: DataWidth] <= rspdata_i.
    - If k = N-1, go to DONE; else k++ and go to REQ.
- DONE: done_o = 1 and error_o = error flag for exactly one cycle, then IDLE.
- error_o is 0 whenever done_o is 0.
- digest_o holds its value between read commands. An errored word is not written; words read before the error keep their new values.
- Responses arriving outside RSP are ignored, since rspready_o = 0.
- Zero-wait timing:
  - Handshake at cycle 0; word k in REQ at cycle 1+2k and in RSP at 2+2k.
  - Write: done_o at cycle 17.
  - Read: done_o at cycle 9.
- Address arithmetic is truncated to AddrWidth; wrap is not checked.

Test Plan:
- Write, zero-wait slave: block_i = {64'h7..., ..., 64'h0} with word i = i → 8 writes to addresses 0x00, 0x08, ..., 0x38; data i; strobe 8'hFF; done_o=1 and error_o=0 at cycle 17.
- Read, zero-wait: slave returns 64'hA0+i for word i → reads at 0x40..0x58; digest_o = {A3,A2,A1,A0}; done_o at cycle 9.
- Backpressure: reqready_i low 3 cycles on word 2, rspvalid_i delayed 2 cycles on word 5 → request outputs stable throughout; done_o at cycle 17+5=22.
- Error: rsperror_i=1 on read word 1 → no request for words 2-3; done_o=1 and error_o=1; digest_o word 0 updated, word 1 unchanged.
- Reset mid-write after word 3 → all outputs 0 at once; no done_o; next command restarts at word 0, address 0x00.
- ByteAlign=0 → write addresses 0..7, read addresses 0x40..0x43; cmd_valid_i while busy → cmd_ready_o=0 and the command is not taken.
